rf_wr_port_arbiter: RTL

- Round-robin arbiter that shares the single register-file write port among four requesters: ALU writeback, load unit, multiplier, link/branch.
- Issues a registered one-hot grant plus its 2-bit code. The code drives the write-select decoder, and `wr_en` drives that decoder's enable.
- A grant is held across multi-cycle bursts until the owner signals `last` or drops its request.
- Sits between the writeback sources and the register-file write-address/data mux.

---
 rtl/rf_wr_port_arbiter_if.sv | 22 ++
 rtl/rf_wr_port_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/rf_wr_port_arbiter_if.sv
// rtl/rf_wr_port_arbiter_if.sv - request/grant bundle between writeback sources and the write-port arbiter
interface rf_wr_port_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] last;
  logic [NREQ-1:0] gnt;
  logic [1:0]      gnt_code;
  logic            gnt_valid;
  logic            wr_en;
  logic            timeout;

  modport master (
    output req, last,
    input  gnt, gnt_code, gnt_valid, wr_en, timeout
  );

  modport slave (
    input  req, last,
    output gnt, gnt_code, gnt_valid, wr_en, timeout
  );
endinterface

// File: rtl/rf_wr_port_arbiter.sv
// rtl/rf_wr_port_arbiter.sv - round-robin owner arbiter for the single register-file write port
// Optional forced release after MAX_HOLD cycles: define RF_ARB_HOLD_TIMEOUT_EN.
module rf_wr_port_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  rf_wr_port_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [1:0]  gnt_code_q, gnt_code_d;
  logic        gnt_valid_q, gnt_valid_d;

  logic [1:0]  owner;
  logic        nat_rel;
  logic        expire;
  logic        release_c;
  logic        new_grant;
  logic [3:0]  cand;
  logic [1:0]  base;
  logic [1:0]  idx;
  logic        found;
  logic [1:0]  win;

  assign owner = gnt_code_q;

  // Owner lets go either by flagging its last beat or by dropping its request.
  assign nat_rel   = (state_q == BUSY) && (!bus.req[owner] || bus.last[owner]);
  assign release_c = nat_rel || expire;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    gnt_code_d  = gnt_code_q;
    gnt_valid_d = gnt_valid_q;
    new_grant   = 1'b0;
    cand        = 4'b0000;
    base        = ptr_q;
    idx         = 2'd0;
    found       = 1'b0;
    win         = 2'd0;

    if (state_q == IDLE) begin
      cand = bus.req;
    end else if (release_c) begin
      // Releasing owner is excluded from this round and drops to lowest priority.
      base  = owner + 2'd1;
      ptr_d = owner + 2'd1;
      cand  = bus.req & ~(4'b0001 << owner);
    end

    for (int i = 0; i < 4; i++) begin
      idx = base + 2'(i);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    if (state_q == IDLE || release_c) begin
      if (found) begin
        state_d     = BUSY;
        gnt_d       = 4'b0001 << win;
        gnt_code_d  = win;
        gnt_valid_d = 1'b1;
        new_grant   = 1'b1;
      end else begin
        state_d     = IDLE;
        gnt_d       = 4'b0000;
        gnt_code_d  = 2'd0;
        gnt_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      gnt_q       <= 4'b0000;
      gnt_code_q  <= 2'd0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_code_q  <= gnt_code_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

`ifdef RF_ARB_HOLD_TIMEOUT_EN
  localparam logic [4:0] HOLD_LAST = 5'(MAX_HOLD - 1);

  logic [4:0] hold_cnt_q, hold_cnt_d;
  logic       timeout_q, timeout_d;

  assign expire = (state_q == BUSY) && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (new_grant || state_d == IDLE) begin
      hold_cnt_d = 5'd0;
    end else if (state_q == BUSY) begin
      hold_cnt_d = hold_cnt_q + 5'd1;
    end
    // Only flag a revocation the owner did not ask for itself.
    timeout_d = expire && !nat_rel;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt_q <= 5'd0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign expire      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.gnt       = gnt_q;
  assign bus.gnt_code  = gnt_code_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.wr_en     = gnt_valid_q & bus.req[gnt_code_q];

endmodule
